// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, rotate-unit control
// field positions and the flag bundle that result-producing stages present.
package alu_pkg;

    localparam int BUS_WIDTH      = 8;
    localparam int BUS_WIDTH_BITS = 3;

    // Bit positions inside the rotate-unit control word (rs_b)
    localparam int RS_THRU    = BUS_WIDTH_BITS + 1;
    localparam int RS_DIR     = BUS_WIDTH_BITS;
    localparam int RS_AMT_MSB = BUS_WIDTH_BITS - 1;
    localparam int RS_AMT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic cout;
    } flags_t;

    // Build a rotate-unit control word from its fields
    function automatic logic [BUS_WIDTH_BITS+1:0] make_rs_b(
        input logic                      thru,
        input logic                      left,
        input logic [BUS_WIDTH_BITS-1:0] amt
    );
        logic [BUS_WIDTH_BITS+1:0] w;
        w                         = '0;
        w[RS_THRU]                = thru;
        w[RS_DIR]                 = left;
        w[RS_AMT_MSB:RS_AMT_LSB]  = amt;
        return w;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero / negative flag generation for a data word.
// Kept separate so other ALU stages can share the same flag logic.
module alu_flag_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_zero,
    output logic             o_neg
);

    assign o_zero = (i_word == {WIDTH{1'b0}});
    assign o_neg  = i_word[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle rotate sequencer. The external rotate unit is only trusted for
// single-bit rotations, so an N-bit request is carried out as N single-bit
// steps, feeding the unit's result back into the work register each clock.
module shift_sequencer
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH      = alu_pkg::BUS_WIDTH,
    parameter int BUS_WIDTH_BITS = alu_pkg::BUS_WIDTH_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // request handshake
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_WIDTH-1:0]      req_a,
    input  logic [BUS_WIDTH_BITS-1:0] req_amt,
    input  logic                      req_left,
    input  logic                      req_thru_carry,
    input  logic                      req_cin,
    // rotate unit interface
    output logic [BUS_WIDTH-1:0]      rs_a,
    output logic [BUS_WIDTH_BITS+1:0] rs_b,
    output logic                      rs_cin,
    input  logic [BUS_WIDTH-1:0]      rs_y,
    input  logic                      rs_cout,
    // result handshake
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [BUS_WIDTH-1:0]      res_y,
    output logic                      res_cout,
    output logic                      res_zero,
    output logic                      res_neg,
    output logic                      busy
);

    localparam logic [BUS_WIDTH_BITS-1:0] ONE_STEP  = BUS_WIDTH_BITS'(1);
    localparam logic [BUS_WIDTH_BITS-1:0] ZERO_STEP = {BUS_WIDTH_BITS{1'b0}};

    seq_state_e                r_state;
    seq_state_e                w_state_next;
    logic [BUS_WIDTH-1:0]      r_work;
    logic                      r_carry;
    logic [BUS_WIDTH_BITS-1:0] r_count;
    logic                      r_left;
    logic                      r_thru;

    logic                      w_accept;
    logic                      w_zero;
    logic                      w_neg;
    flags_t                    w_flags;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    alu_flag_gen #(
        .WIDTH (BUS_WIDTH)
    ) u_flag_gen (
        .i_word (r_work),
        .o_zero (w_zero),
        .o_neg  (w_neg)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (req_amt == ZERO_STEP) ? ST_DONE : ST_STEP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (r_count == ONE_STEP) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_STEP;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture the request, then fold one rotate-unit step per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= {BUS_WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_count <= ZERO_STEP;
            r_left  <= 1'b0;
            r_thru  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_work  <= req_a;
                        r_carry <= req_cin;
                        r_count <= req_amt;
                        r_left  <= req_left;
                        r_thru  <= req_thru_carry;
                    end
                end
                ST_STEP: begin
                    // carry-out is registered even when the unit just passes it through
                    r_work  <= rs_y;
                    r_carry <= rs_cout;
                    r_count <= r_count - ONE_STEP;
                end
                ST_DONE: begin
                    r_work  <= r_work;
                    r_carry <= r_carry;
                end
                default: begin
                    r_work  <= {BUS_WIDTH{1'b0}};
                    r_carry <= 1'b0;
                    r_count <= ZERO_STEP;
                end
            endcase
        end
    end

    // Output decode from registered state; rotate unit only sees a non-zero
    // control word while stepping, and always a rotation of exactly one
    always_comb begin
        w_flags.zero = w_zero;
        w_flags.neg  = w_neg;
        w_flags.cout = r_carry;

        rs_a   = r_work;
        rs_cin = r_carry;
        if (r_state == ST_STEP) begin
            rs_b = make_rs_b(r_thru, r_left, ONE_STEP);
        end else begin
            rs_b = {(BUS_WIDTH_BITS+2){1'b0}};
        end

        req_ready = (r_state == ST_IDLE);
        res_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_STEP) || (r_state == ST_DONE);
        res_y     = r_work;
        res_cout  = w_flags.cout;
        res_zero  = w_flags.zero;
        res_neg   = w_flags.neg;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural rotate unit in the loop.
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int WB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_a = 8'h00;
    logic [WB-1:0] req_amt = 3'd0;
    logic          req_left = 1'b0;
    logic          req_thru_carry = 1'b0;
    logic          req_cin = 1'b0;
    logic [W-1:0]  rs_a;
    logic [WB+1:0] rs_b;
    logic          rs_cin;
    logic [W-1:0]  rs_y;
    logic          rs_cout;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_y;
    logic          res_cout;
    logic          res_zero;
    logic          res_neg;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.BUS_WIDTH(W), .BUS_WIDTH_BITS(WB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
        .req_amt(req_amt), .req_left(req_left), .req_thru_carry(req_thru_carry),
        .req_cin(req_cin),
        .rs_a(rs_a), .rs_b(rs_b), .rs_cin(rs_cin), .rs_y(rs_y), .rs_cout(rs_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_cout(res_cout), .res_zero(res_zero), .res_neg(res_neg), .busy(busy)
    );

    // Behavioural rotate unit: rotates rs_a by rs_b amount, 9-bit through carry if selected
    always_comb begin
        logic [W-1:0] y;
        logic         c;
        y = rs_a;
        c = rs_cin;
        for (int i = 0; i < W; i++) begin
            if (i < int'(rs_b[WB-1:0])) begin
                if (rs_b[WB+1]) begin
                    if (rs_b[WB]) {c, y} = {y, c};
                    else          {c, y} = {y[0], c, y[W-1:1]};
                end else begin
                    if (rs_b[WB]) y = {y[W-2:0], y[W-1]};
                    else          y = {y[0], y[W-1:1]};
                end
            end
        end
        rs_y    = y;
        rs_cout = c;
    end

    typedef struct {
        logic [W-1:0]  a;
        logic [WB-1:0] amt;
        logic          left;
        logic          thru;
        logic          cin;
        logic [W-1:0]  exp_y;
        logic          exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: present request, wait for accept, step to result and check it
    task automatic start_req(input vec_t v, input string tag);
        int  guard = 0;
        int  lat   = 0;
        int  steps = 0;
        bit  done  = 1'b0;
        logic [WB+1:0] step_b;
        step_b = {v.thru, v.left, 3'd1};
        req_a = v.a; req_amt = v.amt; req_left = v.left;
        req_thru_carry = v.thru; req_cin = v.cin; req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        if (!req_ready) check({tag, " accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            if (lat == 0) req_valid = 1'b0;
            lat++;
            if (res_valid || lat > 20) begin
                done = 1'b1;
            end else begin
                if (rs_b === step_b) steps++;
                @(posedge clk);
            end
        end
        check({tag, " latency"},  lat, int'(v.amt) + 1);
        check({tag, " steps"},    steps, int'(v.amt));
        check({tag, " res_y"},    res_y, v.exp_y);
        check({tag, " res_cout"}, res_cout, v.exp_cout);
        check({tag, " res_zero"}, res_zero, (v.exp_y == 8'h00));
        check({tag, " res_neg"},  res_neg, v.exp_y[W-1]);
        check({tag, " busy"},     busy, 1'b1);
        check({tag, " req_ready_done"}, req_ready, 1'b0);
    endtask

    // Called at a negedge in DONE: take the result and confirm return to idle
    task automatic finish_res(input string tag);
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready = 1'b0;
        check({tag, " res_valid_after"}, res_valid, 1'b0);
        check({tag, " busy_after"},      busy, 1'b0);
        check({tag, " req_ready_after"}, req_ready, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " res_valid"}, res_valid, 1'b0);
        check({tag, " res_y"},     res_y, 8'h00);
        check({tag, " res_cout"},  res_cout, 1'b0);
        check({tag, " res_zero"},  res_zero, 1'b1);
        check({tag, " res_neg"},   res_neg, 1'b0);
        check({tag, " busy"},      busy, 1'b0);
        check({tag, " rs_a"},      rs_a, 8'h00);
        check({tag, " rs_b"},      rs_b, 5'h00);
        check({tag, " rs_cin"},    rs_cin, 1'b0);
    endtask

    initial begin
        //            a      amt   left  thru  cin   exp_y  exp_cout
        vecs[0] = '{8'h81, 3'd1, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0};
        vecs[1] = '{8'h81, 3'd1, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1};
        vecs[2] = '{8'hB4, 3'd3, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0};
        vecs[3] = '{8'h01, 3'd1, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1};
        vecs[4] = '{8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'h01, 3'd7, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1};
        vecs[6] = '{8'hA5, 3'd4, 1'b1, 1'b1, 1'b1, 8'h5D, 1'b0};
        vecs[7] = '{8'h03, 3'd2, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1};

        #2;
        check_reset_vals("por");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("por req_ready", req_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            start_req(vecs[i], $sformatf("vec%0d", i));
            finish_res($sformatf("vec%0d", i));
        end

        // Backpressure: hold result 5 clocks with a second request waiting
        start_req(vecs[2], "bp");
        req_a = vecs[1].a; req_amt = vecs[1].amt; req_left = vecs[1].left;
        req_thru_carry = vecs[1].thru; req_cin = vecs[1].cin; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); @(negedge clk);
            check("bp hold res_y",     res_y, 8'h96);
            check("bp hold res_cout",  res_cout, 1'b0);
            check("bp hold res_valid", res_valid, 1'b1);
            check("bp hold req_ready", req_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        res_ready = 1'b0;
        check("bp released res_valid", res_valid, 1'b0);
        check("bp released busy", busy, 1'b0);
        start_req(vecs[1], "bp2");
        finish_res("bp2");

        // Asynchronous reset in the middle of a 7-step rotation
        req_a = 8'h5A; req_amt = 3'd7; req_left = 1'b1;
        req_thru_carry = 1'b1; req_cin = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("mid busy", busy, 1'b1);
        rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst req_ready", req_ready, 1'b1);
        start_req(vecs[0], "postrst");
        finish_res("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
